// File: rtl/round_sat_out_fifo.sv
// Output stage: round-half-up with saturation from IN_W to OUT_W bits, then a small
// valid/ready FIFO so a stalling consumer never stalls the free-running datapath.
module round_sat_out_fifo #(
  parameter int IN_W  = 25,
  parameter int OUT_W = 16,
  parameter int SHIFT = 9,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] data_out,
  output logic [7:0]              sat_cnt,
  output logic [7:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic signed [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_W:0] MAXV = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] MINV = ~MAXV;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic signed [IN_W:0]    tmp;
  logic signed [IN_W:0]    rnd;
  logic                    sat_hi;
  logic                    sat_lo;
  logic signed [OUT_W-1:0] res;

  logic                    st_valid;
  logic                    st_sat;
  logic signed [OUT_W-1:0] st_data;

  logic signed [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             count;
  logic signed [OUT_W-1:0] last_out;

  logic full;
  logic pop;
  logic push;
  logic drop;

  // The extra headroom bit keeps the rounding offset from overflowing at the positive limit.
  always_comb begin
    tmp    = {data_in[IN_W-1], data_in} + HALF;
    rnd    = tmp >>> SHIFT;
    sat_hi = rnd > MAXV;
    sat_lo = rnd < MINV;
    res    = rnd[OUT_W-1:0];
    if (sat_hi) begin
      res = MAXV[OUT_W-1:0];
    end else if (sat_lo) begin
      res = MINV[OUT_W-1:0];
    end
  end

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = st_valid && (!full || pop);
  assign drop      = st_valid && full && !pop;
  assign data_out  = out_valid ? mem[rd_ptr] : last_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_valid <= 1'b0;
      st_sat   <= 1'b0;
      st_data  <= '0;
    end else begin
      st_valid <= in_valid;
      if (in_valid) begin
        st_sat  <= sat_hi || sat_lo;
        st_data <= res;
      end
    end
  end

  // Storage carries no reset; occupancy and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= st_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_out <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_out <= mem[rd_ptr];
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Saturation is counted as a sample leaves the stage register, even if it is then dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (st_valid && st_sat && (sat_cnt != 8'hFF)) begin
        sat_cnt <= sat_cnt + 1'b1;
      end
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_round_sat_out_fifo.sv
// Directed, table-driven bench for round_sat_out_fifo at default parameters.
module tb_round_sat_out_fifo;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic signed [24:0] data_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] data_out;
  logic [7:0]         sat_cnt;
  logic [7:0]         drop_cnt;

  int checks;
  int failures;

  typedef struct {
    logic iv;
    int   din;
    int   evalid;
    int   edata;
    int   esat;
  } vec_t;

  vec_t tbl[10];
  int   heads[8];

  round_sat_out_fifo dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .data_in(data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .sat_cnt(sat_cnt),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input int din);
    in_valid = iv;
    data_in  = 25'(din);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b1, 512 * 5);

    // Reset held while input toggles: everything stays cleared.
    repeat (3) tick();
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_data", int'(data_out), 0);
    checkOutput("rst_sat", int'(sat_cnt), 0);
    checkOutput("rst_drop", int'(drop_cnt), 0);

    reset = 1'b1;
    applyStimulus(1'b1, 512 * 3);
    tick();
    applyStimulus(1'b0, 0);
    checkOutput("lat_edge1_valid", int'(out_valid), 0);
    tick();
    checkOutput("lat_edge2_valid", int'(out_valid), 1);
    checkOutput("lat_edge2_data", int'(data_out), 3);
    tick();

    // Rounding and saturation vectors; expected values are the state after each edge.
    tbl[0] = '{1'b1, 255,       0, 3,      0};
    tbl[1] = '{1'b1, 256,       1, 0,      0};
    tbl[2] = '{1'b1, -256,      1, 1,      0};
    tbl[3] = '{1'b1, -257,      1, 0,      0};
    tbl[4] = '{1'b0, 0,         1, -1,     0};
    tbl[5] = '{1'b0, 0,         0, -1,     0};
    tbl[6] = '{1'b1, 16777215,  0, -1,     0};
    tbl[7] = '{1'b1, -16777216, 1, 32767,  1};
    tbl[8] = '{1'b0, 0,         1, -32768, 1};
    tbl[9] = '{1'b0, 0,         0, -32768, 1};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].iv, tbl[i].din);
      tick();
      checkOutput($sformatf("vec%0d_valid", i), int'(out_valid), tbl[i].evalid);
      checkOutput($sformatf("vec%0d_data", i), int'(data_out), tbl[i].edata);
      checkOutput($sformatf("vec%0d_sat", i), int'(sat_cnt), tbl[i].esat);
    end
    checkOutput("vec_drop", int'(drop_cnt), 0);

    // Overflow: six samples into a stalled FIFO, last two are dropped.
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 512 * k);
      tick();
    end
    applyStimulus(1'b0, 0);
    tick();
    checkOutput("ovf_drop", int'(drop_cnt), 2);
    checkOutput("ovf_valid", int'(out_valid), 1);
    checkOutput("ovf_head", int'(data_out), 1);
    out_ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      tick();
      checkOutput($sformatf("drain%0d_valid", k), int'(out_valid), 1);
      checkOutput($sformatf("drain%0d_data", k), int'(data_out), k);
    end
    tick();
    checkOutput("drain_empty", int'(out_valid), 0);
    checkOutput("drain_hold", int'(data_out), 4);
    checkOutput("drain_sat", int'(sat_cnt), 1);

    // Full FIFO plus a loaded stage register, then continuous push with pop.
    out_ready = 1'b0;
    for (int k = 21; k <= 25; k++) begin
      applyStimulus(1'b1, 512 * k);
      tick();
    end
    checkOutput("full_head", int'(data_out), 21);
    checkOutput("full_drop", int'(drop_cnt), 2);
    heads = '{22, 23, 24, 25, 31, 32, 33, 34};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 512 * (31 + i));
      tick();
      checkOutput($sformatf("fp%0d_valid", i), int'(out_valid), 1);
      checkOutput($sformatf("fp%0d_data", i), int'(data_out), heads[i]);
    end
    checkOutput("fp_drop", int'(drop_cnt), 2);
    applyStimulus(1'b0, 0);
    repeat (8) tick();
    checkOutput("fp_drained", int'(out_valid), 0);

    // Asynchronous reset between edges with three entries queued.
    out_ready = 1'b0;
    for (int k = 41; k <= 43; k++) begin
      applyStimulus(1'b1, 512 * k);
      tick();
    end
    applyStimulus(1'b0, 0);
    tick();
    checkOutput("ar_pre_valid", int'(out_valid), 1);
    checkOutput("ar_pre_head", int'(data_out), 41);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("ar_valid", int'(out_valid), 0);
    checkOutput("ar_data", int'(data_out), 0);
    checkOutput("ar_sat", int'(sat_cnt), 0);
    checkOutput("ar_drop", int'(drop_cnt), 0);
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    applyStimulus(1'b1, 512 * 7);
    tick();
    applyStimulus(1'b0, 0);
    checkOutput("ar_post_e1", int'(out_valid), 0);
    tick();
    checkOutput("ar_post_valid", int'(out_valid), 1);
    checkOutput("ar_post_data", int'(data_out), 7);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
